// File: rtl/sat_ctrl_pkg.sv
// Shared types for the sat phase controller: FSM states, result codes, analyze length.
package sat_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_IMPLY, S_IMPLY_CHK, S_ANALYZE, S_ANA_CHK, S_BKT, S_DECIDE, S_DONE
   } state_t;

   typedef enum logic [1:0] {
      RES_SAT     = 2'b00,
      RES_UNSAT   = 2'b01,
      RES_BKT_OUT = 2'b10,
      RES_ABORT   = 2'b11
   } result_t;

   // learnt_lit settles in the first cycle, max_lvl in the second
   localparam int ANALYZE_CYC = 2;

endpackage

// File: rtl/sat_phase_ctrl_if.sv
// Bin-manager handshake: start with base level, done pulse with result code.
interface sat_phase_ctrl_if #(
   parameter int WIDTH_LVL = 10
);
   logic                 start_i;
   logic [WIDTH_LVL-1:0] base_lvl_i;
   logic                 done_o;
   logic [1:0]           result_o;

   modport master (output start_i, base_lvl_i, input done_o, result_o);
   modport slave  (input start_i, base_lvl_i, output done_o, result_o);
endinterface

// File: rtl/sat_phase_ctrl_lvl_max.sv
// lvl_max_below: largest slice max_lvl strictly below cur_lvl, 0 when none; balanced max tree.
module lvl_max_below #(
   parameter int NUM_VARS  = 8,
   parameter int WIDTH_LVL = 10
) (
   input  logic [NUM_VARS*WIDTH_LVL-1:0] lvl,
   input  logic [WIDTH_LVL-1:0]          cur_lvl,
   output logic [WIDTH_LVL-1:0]          bkt
);
   localparam int NP = 1 << $clog2(NUM_VARS);

   logic [NUM_VARS-1:0][WIDTH_LVL-1:0] lvls;
   logic [WIDTH_LVL-1:0]               node [1:2*NP-1];

   assign lvls = lvl;

   // masked-out and padding leaves read as 0, which is also the "none below" answer
   for (genvar k = 0; k < NP; k++) begin : g_leaf
      if (k < NUM_VARS) begin : g_live
         assign node[NP+k] = (lvls[k] < cur_lvl) ? lvls[k] : '0;
      end else begin : g_pad
         assign node[NP+k] = '0;
      end
   end

   for (genvar i = 1; i < NP; i++) begin : g_node
      assign node[i] = (node[2*i] > node[2*i+1]) ? node[2*i] : node[2*i+1];
   end

   assign bkt = node[1];
endmodule

// File: rtl/sat_phase_ctrl.sv
// sat_phase_ctrl: sequences one bin's var slices through imply/analyze/backtrack/decide.
// Define SAT_CTRL_STATS_EN to add saturating decide/conflict counters.
module sat_phase_ctrl
   import sat_ctrl_pkg::*;
#(
   parameter int NUM_VARS       = 8,
   parameter int WIDTH_LVL      = 10,
   parameter int IMPLY_MAX_ITER = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   sat_phase_ctrl_if.slave               bm,
   input  logic [NUM_VARS-1:0]           var_free_i,
   input  logic [NUM_VARS-1:0]           find_imply_i,
   input  logic [NUM_VARS-1:0]           find_conflict_i,
   input  logic [NUM_VARS*WIDTH_LVL-1:0] max_lvl_i,
   output logic [NUM_VARS-1:0]           valid_from_decision_o,
   output logic                          apply_imply_o,
   output logic                          apply_analyze_o,
   output logic                          apply_bkt_o,
`ifdef SAT_CTRL_STATS_EN
   output logic [15:0]                   n_decide_o,
   output logic [15:0]                   n_conflict_o,
`endif
   output logic [WIDTH_LVL-1:0]          cur_lvl_o,
   output logic [WIDTH_LVL-1:0]          bkt_lvl_o
);
   localparam int CW = $clog2(NUM_VARS + 1);
   localparam int IW = $clog2(IMPLY_MAX_ITER + 1);
   localparam int AW = (ANALYZE_CYC > 1) ? $clog2(ANALYZE_CYC) : 1;

   state_t               state;
   result_t              result;
   logic                 done;
   logic [IW-1:0]        iter;
   logic [IW-1:0]        iter_inc;
   logic [CW-1:0]        prev_cnt;
   logic [CW-1:0]        imp_cnt;
   logic [AW-1:0]        ana_cnt;
   logic [WIDTH_LVL-1:0] base_lvl;
   logic [WIDTH_LVL-1:0] bkt;
   logic [NUM_VARS-1:0]  free_low;

   assign bm.done_o   = done;
   assign bm.result_o = result;

   lvl_max_below #(.NUM_VARS(NUM_VARS), .WIDTH_LVL(WIDTH_LVL)) u_max (
      .lvl     (max_lvl_i),
      .cur_lvl (cur_lvl_o),
      .bkt     (bkt)
   );

   always_comb begin
      imp_cnt = '0;
      for (int k = 0; k < NUM_VARS; k++) imp_cnt = imp_cnt + CW'(find_imply_i[k]);
   end

   assign iter_inc = iter + IW'(1);
   assign free_low = var_free_i & (~var_free_i + NUM_VARS'(1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state                 <= S_IDLE;
         valid_from_decision_o <= '0;
         apply_imply_o         <= 1'b0;
         apply_analyze_o       <= 1'b0;
         apply_bkt_o           <= 1'b0;
         cur_lvl_o             <= '0;
         bkt_lvl_o             <= '0;
         base_lvl              <= '0;
         done                  <= 1'b0;
         result                <= RES_SAT;
         iter                  <= '0;
         prev_cnt              <= '0;
         ana_cnt               <= '0;
      end else begin
         valid_from_decision_o <= '0;
         apply_imply_o         <= 1'b0;
         apply_bkt_o           <= 1'b0;
         done                  <= 1'b0;
         case (state)
            S_IDLE: if (bm.start_i) begin
               cur_lvl_o     <= bm.base_lvl_i;
               base_lvl      <= bm.base_lvl_i;
               iter          <= '0;
               prev_cnt      <= '0;
               apply_imply_o <= 1'b1;
               state         <= S_IMPLY;
            end
            S_IMPLY: state <= S_IMPLY_CHK;
            // Strobes are registered, so the decide choice is made here and the
            // DECIDE cycle itself carries the one-hot strobe and the new level.
            S_IMPLY_CHK: begin
               if (|find_conflict_i) begin
                  apply_analyze_o <= 1'b1;
                  ana_cnt         <= '0;
                  state           <= S_ANALYZE;
               end else if (imp_cnt > prev_cnt) begin
                  if (iter_inc == IW'(IMPLY_MAX_ITER)) begin
                     result <= RES_ABORT;
                     done   <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     iter          <= iter_inc;
                     prev_cnt      <= imp_cnt;
                     apply_imply_o <= 1'b1;
                     state         <= S_IMPLY;
                  end
               end else if (var_free_i == '0) begin
                  result <= RES_SAT;
                  done   <= 1'b1;
                  state  <= S_DONE;
               end else if (&cur_lvl_o) begin
                  result <= RES_ABORT;
                  done   <= 1'b1;
                  state  <= S_DONE;
               end else begin
                  valid_from_decision_o <= free_low;
                  cur_lvl_o             <= cur_lvl_o + WIDTH_LVL'(1);
                  state                 <= S_DECIDE;
               end
            end
            S_ANALYZE: begin
               if (ana_cnt == AW'(ANALYZE_CYC - 1)) state <= S_ANA_CHK;
               else ana_cnt <= ana_cnt + AW'(1);
            end
            S_ANA_CHK: begin
               apply_analyze_o <= 1'b0;
               if (cur_lvl_o == '0) begin
                  result <= RES_UNSAT;
                  done   <= 1'b1;
                  state  <= S_DONE;
               end else if (bkt < base_lvl) begin
                  bkt_lvl_o <= bkt;
                  result    <= RES_BKT_OUT;
                  done      <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  bkt_lvl_o   <= bkt;
                  apply_bkt_o <= 1'b1;
                  state       <= S_BKT;
               end
            end
            S_BKT: begin
               cur_lvl_o     <= bkt_lvl_o;
               iter          <= '0;
               prev_cnt      <= '0;
               apply_imply_o <= 1'b1;
               state         <= S_IMPLY;
            end
            S_DECIDE: begin
               apply_imply_o <= 1'b1;
               state         <= S_IMPLY;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef SAT_CTRL_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         n_decide_o   <= '0;
         n_conflict_o <= '0;
      end else if (state == S_IDLE && bm.start_i) begin
         n_decide_o   <= '0;
         n_conflict_o <= '0;
      end else begin
         if (state == S_DECIDE && n_decide_o != 16'hFFFF) n_decide_o <= n_decide_o + 16'd1;
         if (state == S_ANALYZE && ana_cnt == '0 && n_conflict_o != 16'hFFFF)
            n_conflict_o <= n_conflict_o + 16'd1;
      end
   end
`endif

endmodule
